seven_seg_scanner: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It holds a packed multi-digit BCD value and selects one digit per scan slot. Each selected nibble goes to the downstream BCD-to-7-segment decoder through the BCD output, and the matching active-low anode enable is driven. It adds anti-ghosting blank intervals, optional leading-zero blanking and tear-free value updates at frame boundaries.

---
 rtl/seven_seg_scanner_pkg.sv | 14 +
 rtl/seven_seg_scanner_scan_timer.sv | 46 ++++
 rtl/seven_seg_scanner.sv | 135 +++++++++++++
 tb/tb_seven_seg_scanner.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scanner_pkg.sv
// Shared types and board-clock defaults for the 7-segment scan controller.
// Holds the scan FSM state type and the digit-index width.
package seven_seg_scanner_pkg;

    localparam int DEF_SCAN_DIV     = 100000;
    localparam int DEF_BLANK_CYCLES = 1000;
    localparam int IDX_W            = 3;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scanState_e;

endpackage

// File: rtl/seven_seg_scanner_scan_timer.sv
// Slot counter and digit index for the display scan. The event flags are high during
// the cycle whose closing edge starts a slot, starts the lit window, or starts a frame.
module seven_seg_scanner_scan_timer
    import seven_seg_scanner_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = DEF_SCAN_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] digitIdx,
    output logic [IDX_W-1:0] digitNext,
    output logic             slotStart,
    output logic             showStart,
    output logic             frameWrap
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] slotCnt;

    assign slotStart = (slotCnt == CNT_W'(SCAN_DIV - 1));
    assign showStart = (slotCnt == CNT_W'(BLANK_CYCLES - 1));
    assign frameWrap = slotStart && (digitIdx == IDX_W'(N_DIGITS - 1));

    always_comb begin
        digitNext = digitIdx;
        if (frameWrap) begin
            digitNext = '0;
        end else if (slotStart) begin
            digitNext = digitIdx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slotCnt  <= '0;
            digitIdx <= '0;
        end else begin
            slotCnt  <= slotStart ? '0 : slotCnt + 1'b1;
            digitIdx <= digitNext;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner: blank-then-show slots per digit,
// frame-aligned value updates and optional leading-zero blanking.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = DEF_SCAN_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic                  lz_blank_en,
    output logic [3:0]            BCD,
    output logic [N_DIGITS-1:0]   AN,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_done
);

    localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{1'b1}};

    logic [IDX_W-1:0]      digitIdx;
    logic [IDX_W-1:0]      digitNext;
    logic                  slotStart;
    logic                  showStart;
    logic                  frameWrap;

    scanState_e            stateQ, stateD;
    logic [4*N_DIGITS-1:0] shadowQ, shadowD;
    logic [4*N_DIGITS-1:0] displayQ, displayD;
    logic [3:0]            bcdQ, bcdD;
    logic [N_DIGITS-1:0]   anQ, anD;

    seven_seg_scanner_scan_timer #(
        .N_DIGITS    (N_DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .digitIdx (digitIdx),
        .digitNext(digitNext),
        .slotStart(slotStart),
        .showStart(showStart),
        .frameWrap(frameWrap)
    );

    function automatic logic [3:0] nibbleAt(input logic [4*N_DIGITS-1:0] v,
                                            input logic [IDX_W-1:0] idx);
        logic [3:0] res;
        res = 4'h0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) res = v[4*i +: 4];
        end
        return res;
    endfunction

    // Digit k is dark when it and every more-significant digit are zero; digit 0 always lights.
    function automatic logic isBlanked(input logic [4*N_DIGITS-1:0] v,
                                       input logic [IDX_W-1:0] k);
        logic allZero;
        allZero = 1'b1;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (IDX_W'(j) >= k && v[4*j +: 4] != 4'h0) allZero = 1'b0;
        end
        return (k != '0) && allZero;
    endfunction

    function automatic logic [N_DIGITS-1:0] anFor(input logic [IDX_W-1:0] idx);
        logic [N_DIGITS-1:0] res;
        res = AN_OFF;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) res[i] = 1'b0;
        end
        return res;
    endfunction

    always_comb begin
        shadowD  = load ? value_in : shadowQ;
        displayD = displayQ;
        stateD   = stateQ;
        anD      = anQ;
        bcdD     = bcdQ;

        // A load on the frame-start edge bypasses the shadow so the new frame shows it.
        if (frameWrap) begin
            displayD = load ? value_in : shadowQ;
        end

        case (stateQ)
            ST_BLANK: begin
                if (showStart) begin
                    stateD = ST_SHOW;
                    anD    = (lz_blank_en && isBlanked(displayQ, digitIdx)) ? AN_OFF
                                                                             : anFor(digitIdx);
                end
            end
            ST_SHOW: begin
                if (slotStart) begin
                    stateD = ST_BLANK;
                end
            end
            default: stateD = ST_BLANK;
        endcase

        // The nibble settles at slot start, ahead of the anode turning on.
        if (slotStart) begin
            anD  = AN_OFF;
            bcdD = nibbleAt(displayD, digitNext);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= ST_BLANK;
            shadowQ  <= '0;
            displayQ <= '0;
            bcdQ     <= 4'h0;
            anQ      <= AN_OFF;
        end else begin
            stateQ   <= stateD;
            shadowQ  <= shadowD;
            displayQ <= displayD;
            bcdQ     <= bcdD;
            anQ      <= anD;
        end
    end

    assign BCD        = bcdQ;
    assign AN         = anQ;
    assign digit_idx  = digitIdx;
    assign frame_done = frameWrap;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with N_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value_in;
    logic        lz_blank_en;
    logic [3:0]  BCD;
    logic [3:0]  AN;
    logic [2:0]  digit_idx;
    logic        frame_done;

    int nTests = 0;
    int nFail  = 0;
    int anViolations = 0;

    seven_seg_scanner #(
        .N_DIGITS    (4),
        .SCAN_DIV    (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value_in   (value_in),
        .lz_blank_en(lz_blank_en),
        .BCD        (BCD),
        .AN         (AN),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && $countones(~AN) > 1) anViolations++;
    end

    // Per-slot expectations packed as {slot3, slot2, slot1, slot0}.
    typedef struct packed {
        logic [15:0] value;
        logic        lz;
        logic [15:0] bcdExp;
        logic [15:0] anExp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic waitFrameDone();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            nTests++;
            nFail++;
            $display("FAIL frame_done_timeout: got none expected pulse within 200 cycles");
        end
    endtask

    // Checks one whole frame, starting from the frame_done cycle before it.
    task automatic checkFrame(input string tag, input logic [15:0] bcdExp,
                              input logic [15:0] anExp);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                load = 1'b0;
                check($sformatf("%s idx s%0d c%0d", tag, s, c), 32'(digit_idx), 32'(s));
                check($sformatf("%s BCD s%0d c%0d", tag, s, c), 32'(BCD), 32'(bcdExp[4*s +: 4]));
                check($sformatf("%s AN s%0d c%0d", tag, s, c), 32'(AN),
                      (c < 2) ? 32'hF : 32'(anExp[4*s +: 4]));
                check($sformatf("%s fd s%0d c%0d", tag, s, c), 32'(frame_done),
                      (s == 3 && c == 7) ? 32'd1 : 32'd0);
            end
        end
    endtask

    vec_t vecs[7];
    int   gap;

    initial begin
        vecs[0] = '{value: 16'h1234, lz: 1'b0, bcdExp: 16'h1234, anExp: 16'h7BDE};
        vecs[1] = '{value: 16'h0042, lz: 1'b1, bcdExp: 16'h0042, anExp: 16'hFFDE};
        vecs[2] = '{value: 16'h0000, lz: 1'b1, bcdExp: 16'h0000, anExp: 16'hFFFE};
        vecs[3] = '{value: 16'h0042, lz: 1'b0, bcdExp: 16'h0042, anExp: 16'h7BDE};
        vecs[4] = '{value: 16'h0A0F, lz: 1'b1, bcdExp: 16'h0A0F, anExp: 16'hFBDE};
        vecs[5] = '{value: 16'h1000, lz: 1'b1, bcdExp: 16'h1000, anExp: 16'h7BDE};
        vecs[6] = '{value: 16'h0100, lz: 1'b1, bcdExp: 16'h0100, anExp: 16'hFBDE};

        rst_n       = 1'b0;
        load        = 1'b0;
        value_in    = 16'h0;
        lz_blank_en = 1'b0;

        repeat (3) @(negedge clk);
        check("reset AN", 32'(AN), 32'hF);
        check("reset BCD", 32'(BCD), 32'h0);
        check("reset idx", 32'(digit_idx), 32'h0);
        check("reset fd", 32'(frame_done), 32'h0);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            lz_blank_en = vecs[v].lz;
            repeat (5) @(negedge clk);
            load     = 1'b1;
            value_in = vecs[v].value;
            @(negedge clk);
            load = 1'b0;
            waitFrameDone();
            checkFrame($sformatf("vec%0d", v), vecs[v].bcdExp, vecs[v].anExp);
        end

        // Two loads inside one frame: only the later one reaches the display.
        lz_blank_en = 1'b0;
        waitFrameDone();
        repeat (3) @(negedge clk);
        load = 1'b1; value_in = 16'h1111;
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        load = 1'b1; value_in = 16'h2222;
        @(negedge clk);
        load = 1'b0;
        waitFrameDone();
        checkFrame("lastwins", 16'h2222, 16'h7BDE);

        // Load on the frame-wrap cycle goes straight into the starting frame.
        load = 1'b1; value_in = 16'h5678;
        checkFrame("bypass", 16'h5678, 16'h7BDE);

        gap = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            gap++;
            if (frame_done === 1'b1) break;
        end
        check("frame_done period", 32'(gap), 32'd32);
        @(negedge clk);
        check("frame_done width", 32'(frame_done), 32'd0);

        // Reset asserted mid-SHOW of digit 2 (slot 2, cycle 4).
        repeat (20) @(negedge clk);
        check("pre-rst idx", 32'(digit_idx), 32'd2);
        check("pre-rst AN", 32'(AN), 32'hB);
        check("pre-rst BCD", 32'(BCD), 32'h6);
        #2 rst_n = 1'b0;
        #1;
        check("async rst AN", 32'(AN), 32'hF);
        check("async rst BCD", 32'(BCD), 32'h0);
        check("async rst idx", 32'(digit_idx), 32'h0);
        check("async rst fd", 32'(frame_done), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst c1 idx", 32'(digit_idx), 32'h0);
        check("post-rst c1 AN", 32'(AN), 32'hF);
        check("post-rst c1 BCD", 32'(BCD), 32'h0);
        @(negedge clk);
        check("post-rst c2 AN", 32'(AN), 32'hE);
        check("post-rst c2 BCD", 32'(BCD), 32'h0);

        check("AN one-cold violations", 32'(anViolations), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
